// File: rtl/frame_update_scheduler.sv
// Per-frame update sequencer: on entry to vertical blanking, hands start/done
// handshakes to each object client in turn and flags hung clients and overruns.
module frame_update_scheduler #(
   parameter int          N_CLIENTS = 4,
   parameter int          V_ACTIVE  = 480,
   parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [9:0]           x,
   input  logic [9:0]           y,
   input  logic                 p_tick,
   input  logic                 enable,
   input  logic [N_CLIENTS-1:0] upd_done,
   input  logic                 clr_err,
   output logic [N_CLIENTS-1:0] upd_start,
   output logic                 frame_busy,
   output logic [15:0]          frame_count,
   output logic                 overrun,
   output logic [N_CLIENTS-1:0] timeout_err
);

   localparam int                   IDX_W      = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
   localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(N_CLIENTS - 1);
   localparam logic [15:0]          TIMER_LAST = TIMEOUT - 16'd1;
   localparam logic [9:0]           V_ACT      = V_ACTIVE[9:0];
   localparam logic [N_CLIENTS-1:0] ONE        = N_CLIENTS'(1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_DONE} state_t;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [15:0]          timer, timer_nxt;
   logic                 frame_evt;
   logic                 done_cur;
   logic                 line0_evt;
   logic [N_CLIENTS-1:0] start_nxt;
   logic [N_CLIENTS-1:0] terr_set;
   logic                 busy_nxt;
   logic [15:0]          count_nxt;

   assign done_cur  = upd_done[idx];
   assign line0_evt = p_tick && (x == 10'd0) && (y == 10'd0);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (frame_evt && enable) state_nxt = S_START;
            else                     state_nxt = S_IDLE;
         end
         S_START: state_nxt = S_WAIT;
         S_WAIT: begin
            if (done_cur)                  state_nxt = S_NEXT;
            else if (timer == TIMER_LAST)  state_nxt = S_NEXT;
            else                           state_nxt = S_WAIT;
         end
         S_NEXT: begin
            if (idx == LAST_IDX) state_nxt = S_DONE;
            else                 state_nxt = S_START;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      idx_nxt   = idx;
      timer_nxt = timer;
      start_nxt = '0;
      terr_set  = '0;
      busy_nxt  = frame_busy;
      count_nxt = frame_count;
      case (state)
         S_IDLE: begin
            if (frame_evt && enable) begin
               idx_nxt  = '0;
               busy_nxt = 1'b1;
            end else begin
               busy_nxt = frame_busy;
            end
         end
         S_START: begin
            start_nxt = ONE << idx;
            timer_nxt = 16'd0;
         end
         S_WAIT: begin
            // a done arriving on the timeout cycle wins over the error
            if (done_cur)                 timer_nxt = timer;
            else if (timer == TIMER_LAST) terr_set  = ONE << idx;
            else                          timer_nxt = timer + 16'd1;
         end
         S_NEXT: begin
            if (idx != LAST_IDX) idx_nxt = idx + IDX_W'(1);
            else                 idx_nxt = idx;
         end
         S_DONE: begin
            busy_nxt  = 1'b0;
            count_nxt = frame_count + 16'd1;
         end
         default: idx_nxt = '0;
      endcase
   end

   // Registered outputs and datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         idx         <= '0;
         timer       <= 16'd0;
         frame_evt   <= 1'b0;
         upd_start   <= '0;
         frame_busy  <= 1'b0;
         frame_count <= 16'd0;
         overrun     <= 1'b0;
         timeout_err <= '0;
      end else begin
         idx         <= idx_nxt;
         timer       <= timer_nxt;
         frame_evt   <= p_tick && (x == 10'd0) && (y == V_ACT);
         upd_start   <= start_nxt;
         frame_busy  <= busy_nxt;
         frame_count <= count_nxt;
         if (line0_evt && frame_busy) overrun <= 1'b1;
         else if (clr_err)            overrun <= 1'b0;
         else                         overrun <= overrun;
         timeout_err <= (clr_err ? '0 : timeout_err) | terr_set;
      end
   end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler: table of update-pass scenarios plus
// hand-written sequences for reset mid-pass and idle line-0 behaviour.
module tb_frame_update_scheduler;

   localparam int V_ACT = 480;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  x, y;
   logic        p_tick, enable, clr_err;
   logic [3:0]  upd_done;
   logic [3:0]  upd_start;
   logic        frame_busy;
   logic [15:0] frame_count;
   logic        overrun;
   logic [3:0]  timeout_err;

   int n_checks = 0;
   int n_errors = 0;
   int exp_count = 0;

   frame_update_scheduler #(.N_CLIENTS(4), .V_ACTIVE(V_ACT), .TIMEOUT(16'd16)) dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .p_tick(p_tick), .enable(enable),
      .upd_done(upd_done), .clr_err(clr_err), .upd_start(upd_start),
      .frame_busy(frame_busy), .frame_count(frame_count), .overrun(overrun),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] hang;
      int         delay;
      logic       en;
      int         drop_at;
      int         ovr_at;
      logic [3:0] stray;
      logic [3:0] exp_start;
      logic [3:0] exp_err;
      logic       exp_ovr;
      int         exp_delta;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      p_tick   = 1'b0;
      x        = 10'd5;
      y        = 10'd100;
      clr_err  = 1'b0;
      upd_done = 4'b0000;
   endtask

   task automatic run_vec(input int vi, input vec_t v);
      int         done_at[4];
      logic [3:0] started;
      int         nstart;
      int         first_c;
      started = 4'b0000;
      nstart  = 0;
      first_c = -1;
      for (int k = 0; k < 4; k++) done_at[k] = -1;
      @(negedge clk);
      idle_inputs();
      clr_err = 1'b1;
      enable  = v.en;
      @(negedge clk);
      clr_err = 1'b0;
      check($sformatf("v%0d clr_overrun", vi), {31'd0, overrun}, 32'd0);
      check($sformatf("v%0d clr_timeout", vi), {28'd0, timeout_err}, 32'd0);
      p_tick = 1'b1;
      x      = 10'd0;
      y      = 10'(V_ACT);
      for (int c = 1; c <= 150; c++) begin
         @(negedge clk);
         if (upd_start != 4'b0000) begin
            check($sformatf("v%0d onehot c%0d", vi, c), {31'd0, $onehot(upd_start)}, 32'd1);
            for (int k = 0; k < 4; k++) begin
               if (upd_start[k]) begin
                  check($sformatf("v%0d order", vi), k, nstart);
                  started[k] = 1'b1;
                  if (nstart == 0) first_c = c;
                  nstart++;
                  if (!v.hang[k]) done_at[k] = c + v.delay;
               end
            end
         end
         if (c == 2 && v.exp_start != 4'b0000)
            check($sformatf("v%0d busy_early", vi), {31'd0, frame_busy}, 32'd1);
         idle_inputs();
         for (int k = 0; k < 4; k++) if (done_at[k] == c) upd_done[k] = 1'b1;
         if (c == 5) upd_done = upd_done | v.stray;
         if (c == v.drop_at) enable = 1'b0;
         if (c == v.ovr_at) begin
            p_tick  = 1'b1;
            x       = 10'd0;
            y       = 10'd0;
            clr_err = 1'b1;
         end
      end
      check($sformatf("v%0d started", vi), {28'd0, started}, {28'd0, v.exp_start});
      if (v.exp_start != 4'b0000)
         check($sformatf("v%0d first_latency", vi), first_c, 3);
      check($sformatf("v%0d timeout_err", vi), {28'd0, timeout_err}, {28'd0, v.exp_err});
      check($sformatf("v%0d overrun", vi), {31'd0, overrun}, {31'd0, v.exp_ovr});
      check($sformatf("v%0d busy_end", vi), {31'd0, frame_busy}, 32'd0);
      exp_count += v.exp_delta;
      check($sformatf("v%0d frame_count", vi), {16'd0, frame_count}, exp_count);
      enable = 1'b1;
   endtask

   task automatic reset_mid_wait();
      int done0;
      int rst_at;
      logic seen_late;
      done0     = -1;
      rst_at    = -1;
      seen_late = 1'b0;
      @(negedge clk);
      idle_inputs();
      p_tick = 1'b1;
      x      = 10'd0;
      y      = 10'(V_ACT);
      for (int c = 1; c <= 60 && rst_at < 0; c++) begin
         @(negedge clk);
         idle_inputs();
         if (upd_start[0]) done0 = c + 2;
         if (upd_start[1]) rst_at = c + 3;
         if (c == done0) upd_done[0] = 1'b1;
      end
      check("reach_client1", {31'd0, rst_at >= 0}, 32'd1);
      repeat (3) @(negedge clk);
      check("busy_before_reset", {31'd0, frame_busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_upd_start", {28'd0, upd_start}, 32'd0);
      check("rst_busy", {31'd0, frame_busy}, 32'd0);
      check("rst_count", {16'd0, frame_count}, 32'd0);
      check("rst_flags", {27'd0, overrun, timeout_err}, 32'd0);
      reset     = 1'b0;
      exp_count = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (upd_start != 4'b0000) seen_late = 1'b1;
         upd_done = 4'b1111;
      end
      upd_done = 4'b0000;
      check("no_start_after_reset", {31'd0, seen_late}, 32'd0);
      check("count_after_reset", {16'd0, frame_count}, 32'd0);
   endtask

   initial begin
      //        hang     dly en    drop ovr stray    start    err      ovr   d
      vecs[0] = '{4'b0000, 3, 1'b1, 0, 0,  4'b0000, 4'b1111, 4'b0000, 1'b0, 1};
      vecs[1] = '{4'b0100, 3, 1'b1, 0, 0,  4'b0000, 4'b1111, 4'b0100, 1'b0, 1};
      vecs[2] = '{4'b0000, 3, 1'b0, 0, 0,  4'b0000, 4'b0000, 4'b0000, 1'b0, 0};
      vecs[3] = '{4'b0000, 3, 1'b1, 8, 0,  4'b0000, 4'b1111, 4'b0000, 1'b0, 1};
      vecs[4] = '{4'b0010, 2, 1'b1, 0, 12, 4'b0000, 4'b1111, 4'b0010, 1'b1, 1};
      vecs[5] = '{4'b0001, 2, 1'b1, 0, 0,  4'b1000, 4'b1111, 4'b0001, 1'b0, 1};
      vecs[6] = '{4'b0000, 0, 1'b1, 0, 0,  4'b0000, 4'b1111, 4'b0000, 1'b0, 1};
      vecs[7] = '{4'b0000, 15, 1'b1, 0, 0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1};
      vecs[8] = '{4'b0000, 16, 1'b1, 0, 0, 4'b0000, 4'b1111, 4'b1111, 1'b0, 1};

      reset  = 1'b1;
      enable = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      check("reset_upd_start", {28'd0, upd_start}, 32'd0);
      check("reset_busy", {31'd0, frame_busy}, 32'd0);
      check("reset_count", {16'd0, frame_count}, 32'd0);
      check("reset_flags", {27'd0, overrun, timeout_err}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // line 0 while idle must not raise overrun
      @(negedge clk);
      p_tick = 1'b1;
      x      = 10'd0;
      y      = 10'd0;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      check("idle_line0_no_overrun", {31'd0, overrun}, 32'd0);

      reset_mid_wait();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
